// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle control unit.
// State enum, opcode constants, mux/ULA encodings and control word.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC     = 4'd6,
    RWB      = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] R_FORMAT = 6'b000000;
  localparam logic [5:0] LW       = 6'b100011;
  localparam logic [5:0] SW       = 6'b101011;
  localparam logic [5:0] BEQ      = 6'b000100;
  localparam logic [5:0] BNE      = 6'b000101;
  localparam logic [5:0] ADDI     = 6'b001000;
  localparam logic [5:0] J        = 6'b000010;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;

  localparam logic [1:0] PC_ULA    = 2'b00;
  localparam logic [1:0] PC_ULAOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       regdst;
    logic       ulasrca;
    logic       branch_ne;
    logic [1:0] ulasrcb;
    logic [1:0] ulaop;
    logic [1:0] pcsource;
    logic       illegal_op;
  } ctl_t;

  function automatic logic op_legal(
    input logic [5:0] op,
    input logic       bne_en
  );
    case (op)
      R_FORMAT, LW, SW,
      BEQ, ADDI, J:     return 1'b1;
      BNE:              return bne_en;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control word for the current state.
// Ports: state, op, mem_ready (already WAIT_EN-resolved) -> ctl.
module mc_output_decode
  import mc_pkg::*;
#(
  parameter bit BNE_EN = 1'b1
) (
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output ctl_t       ctl
);

  always_comb begin
    ctl = '0;
    case (state)
      FETCH: begin
        ctl.memread = 1'b1;
        ctl.ulasrcb = SRCB_4;
        ctl.ulaop   = ULA_ADD;
        ctl.irwrite = mem_ready;
        ctl.pcwrite = mem_ready;
      end
      DECODE: begin
        ctl.ulasrcb    = SRCB_IMM_SH;
        ctl.ulaop      = ULA_ADD;
        ctl.illegal_op = ~op_legal(op, BNE_EN);
      end
      MEMADR: begin
        ctl.ulasrca = 1'b1;
        ctl.ulasrcb = SRCB_IMM;
      end
      MEMREAD: begin
        ctl.memread = 1'b1;
        ctl.iord    = 1'b1;
      end
      MEMWB: begin
        ctl.regwrite = 1'b1;
        ctl.memtoreg = 1'b1;
      end
      MEMWRITE: begin
        ctl.memwrite = 1'b1;
        ctl.iord     = 1'b1;
      end
      EXEC: begin
        ctl.ulasrca = 1'b1;
        ctl.ulasrcb = SRCB_B;
        ctl.ulaop   = ULA_FUNCT;
      end
      RWB: begin
        ctl.regdst   = 1'b1;
        ctl.regwrite = 1'b1;
      end
      BRANCH: begin
        ctl.ulasrca     = 1'b1;
        ctl.ulasrcb     = SRCB_B;
        ctl.ulaop       = ULA_SUB;
        ctl.pcwritecond = 1'b1;
        ctl.pcsource    = PC_ULAOUT;
        ctl.branch_ne   = (op == BNE);
      end
      ADDIEX: begin
        ctl.ulasrca = 1'b1;
        ctl.ulasrcb = SRCB_IMM;
      end
      ADDIWB: begin
        ctl.regwrite = 1'b1;
      end
      JUMP: begin
        ctl.pcwrite  = 1'b1;
        ctl.pcsource = PC_JUMP;
      end
      default: ctl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: state register, next state.
// Ports: clk, reset, op, mem_ready -> datapath controls, illegal_op, state.
module multicycle_control
  import mc_pkg::*;
#(
  parameter bit BNE_EN  = 1'b1,
  parameter bit WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       regdst,
  output logic       ULAsrca,
  output logic       branch_ne,
  output logic [1:0] ULAsrcb,
  output logic [1:0] ULAop,
  output logic [1:0] pcsource,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q, state_d;
  ctl_t   ctl, ctl_o;
  logic   rdy;

  // Without waits every memory access is assumed to finish at once.
  assign rdy = WAIT_EN ? mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (rdy) state_d = DECODE;
      DECODE: begin
        state_d = FETCH;
        case (op)
          R_FORMAT: state_d = EXEC;
          LW, SW:   state_d = MEMADR;
          BEQ:      state_d = BRANCH;
          BNE:      if (BNE_EN) state_d = BRANCH;
          ADDI:     state_d = ADDIEX;
          J:        state_d = JUMP;
          default:  state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (op == LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (rdy) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (rdy) state_d = FETCH;
      EXEC:     state_d = RWB;
      RWB:      state_d = FETCH;
      BRANCH:   state_d = FETCH;
      ADDIEX:   state_d = ADDIWB;
      ADDIWB:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  mc_output_decode #(
    .BNE_EN(BNE_EN)
  ) u_dec (
    .state     (state_q),
    .op        (op),
    .mem_ready (rdy),
    .ctl       (ctl)
  );

  // Reset masks the controls in the same cycle so no access can start.
  assign ctl_o = reset ? '0 : ctl;
  assign state = reset ? FETCH : state_q;

  assign pcwrite     = ctl_o.pcwrite;
  assign pcwritecond = ctl_o.pcwritecond;
  assign iord        = ctl_o.iord;
  assign memread     = ctl_o.memread;
  assign memwrite    = ctl_o.memwrite;
  assign irwrite     = ctl_o.irwrite;
  assign memtoreg    = ctl_o.memtoreg;
  assign regwrite    = ctl_o.regwrite;
  assign regdst      = ctl_o.regdst;
  assign ULAsrca     = ctl_o.ulasrca;
  assign branch_ne   = ctl_o.branch_ne;
  assign ULAsrcb     = ctl_o.ulasrcb;
  assign ULAop       = ctl_o.ulaop;
  assign pcsource    = ctl_o.pcsource;
  assign illegal_op  = ctl_o.illegal_op;

endmodule
